// File: rtl/cnn_pkg.sv
// Shared types and sizing helpers for the CNN convolution sequencer.
package cnn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_F,
    LOAD_F_DRN,
    WIN,
    WIN_DRN,
    WRITE,
    DONE
  } state_t;

  // Derived sizes at the default geometry (16x16 image, 4x4 kernel)
  localparam int KK   = 4 * 4;
  localparam int OW   = 16 - 4 + 1;
  localparam int OUTS = OW * OW;

  // Memory address width: room for all kernels plus the image
  function automatic int calc_aw(input int n, input int img, input int k);
    return $clog2(n * k * k + img * img);
  endfunction

  // Output address width: room for every output plus the 8-bit base offset
  function automatic int calc_oaw(input int n, input int img, input int k);
    return $clog2(n * (img - k + 1) * (img - k + 1) + 256);
  endfunction

  // Counter width that never collapses to zero bits
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/cnn_win_addr_gen.sv
// Holds the captured base addresses and forms the memory read address
// and output write address from the sequencer counters.
module cnn_win_addr_gen
  import cnn_pkg::*;
#(
  parameter int IMG = 16,
  parameter int K   = 4,
  parameter int AW  = 9,
  parameter int OAW = 10,
  parameter int FW  = 2,
  parameter int RW  = 4,
  parameter int KW  = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           capture,
  input  logic [AW-1:0]  x_inp,
  input  logic [AW-1:0]  y_inp,
  input  logic [7:0]     z_inp,
  input  logic [FW-1:0]  f,
  input  logic [RW-1:0]  r,
  input  logic [RW-1:0]  c,
  input  logic [KW-1:0]  k,
  input  logic           rd_filter,
  input  logic           rd_window,
  input  logic           wr_out,
  output logic [AW-1:0]  mem_raddr,
  output logic [OAW-1:0] out_addr
);

  localparam int P_KK   = K * K;
  localparam int P_OW   = IMG - K + 1;
  localparam int P_OUTS = P_OW * P_OW;

  logic [AW-1:0] x_q;
  logic [AW-1:0] y_q;
  logic [7:0]    z_q;
  logic [KW-1:0] ki;
  logic [KW-1:0] kj;
  logic [AW-1:0] filt_addr;
  logic [AW-1:0] win_addr;

  // Latch the three bases once per run; later input changes are ignored
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q <= '0;
      y_q <= '0;
      z_q <= '0;
    end else if (capture) begin
      x_q <= x_inp;
      y_q <= y_inp;
      z_q <= z_inp;
    end
  end

  // Split k into kernel row/column and form both address streams, zero when idle
  always_comb begin
    ki        = k / KW'(K);
    kj        = k % KW'(K);
    filt_addr = y_q + AW'(f) * AW'(P_KK) + AW'(k);
    win_addr  = x_q + (AW'(r) + AW'(ki)) * AW'(IMG) + AW'(c) + AW'(kj);
    mem_raddr = '0;
    if (rd_filter) begin
      mem_raddr = filt_addr;
    end else if (rd_window) begin
      mem_raddr = win_addr;
    end
    out_addr = '0;
    if (wr_out) begin
      out_addr = OAW'(z_q) + OAW'(f) * OAW'(P_OUTS) + OAW'(r) * OAW'(P_OW) + OAW'(c);
    end
  end

endmodule

// File: rtl/cnn_seq_ctrl.sv
// Sequencer for the CNN convolution datapath: loads each kernel, slides
// the window over the image and hands one result per window to the writer.
module cnn_seq_ctrl
  import cnn_pkg::*;
#(
  parameter int N   = 4,
  parameter int IMG = 16,
  parameter int K   = 4,
  parameter int AW  = calc_aw(N, IMG, K),
  parameter int OAW = calc_oaw(N, IMG, K)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [AW-1:0]          x_inp,
  input  logic [AW-1:0]          y_inp,
  input  logic [7:0]             z_inp,
  output logic                   mem_ren,
  output logic [AW-1:0]          mem_raddr,
  output logic                   fbuf_we,
  output logic [$clog2(K*K)-1:0] fbuf_idx,
  output logic                   mac_clr,
  output logic                   mac_en,
  output logic [$clog2(K*K)-1:0] mac_k,
  output logic                   out_valid,
  output logic [OAW-1:0]         out_addr,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   done
);

  localparam int P_KK = K * K;
  localparam int P_OW = IMG - K + 1;
  localparam int KW   = $clog2(P_KK);
  localparam int FW   = clog2_min1(N);
  localparam int RW   = clog2_min1(P_OW);

  state_t        state;
  state_t        state_nxt;
  logic [FW-1:0] f;
  logic [FW-1:0] f_nxt;
  logic [RW-1:0] r;
  logic [RW-1:0] r_nxt;
  logic [RW-1:0] c;
  logic [RW-1:0] c_nxt;
  logic [KW-1:0] k;
  logic [KW-1:0] k_nxt;
  logic          rd_filter;
  logic          rd_window;
  logic          capture;

  // State and loop counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      f     <= '0;
      r     <= '0;
      c     <= '0;
      k     <= '0;
    end else begin
      state <= state_nxt;
      f     <= f_nxt;
      r     <= r_nxt;
      c     <= c_nxt;
      k     <= k_nxt;
    end
  end

  // Next state, counter stepping and the per-state strobes
  always_comb begin
    state_nxt = state;
    f_nxt     = f;
    r_nxt     = r;
    c_nxt     = c;
    k_nxt     = k;
    rd_filter = 1'b0;
    rd_window = 1'b0;
    mac_clr   = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    busy      = (state != IDLE);
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          capture   = 1'b1;
          state_nxt = LOAD_F;
          f_nxt     = '0;
          r_nxt     = '0;
          c_nxt     = '0;
          k_nxt     = '0;
        end
      end
      LOAD_F: begin
        rd_filter = 1'b1;
        if (k == KW'(P_KK - 1)) begin
          k_nxt     = '0;
          state_nxt = LOAD_F_DRN;
        end else begin
          k_nxt = k + KW'(1);
        end
      end
      LOAD_F_DRN: begin
        r_nxt     = '0;
        c_nxt     = '0;
        k_nxt     = '0;
        state_nxt = WIN;
      end
      WIN: begin
        rd_window = 1'b1;
        mac_clr   = (k == '0);
        if (k == KW'(P_KK - 1)) begin
          k_nxt     = '0;
          state_nxt = WIN_DRN;
        end else begin
          k_nxt = k + KW'(1);
        end
      end
      WIN_DRN: begin
        state_nxt = WRITE;
      end
      WRITE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (c != RW'(P_OW - 1)) begin
            c_nxt     = c + RW'(1);
            state_nxt = WIN;
          end else if (r != RW'(P_OW - 1)) begin
            c_nxt     = '0;
            r_nxt     = r + RW'(1);
            state_nxt = WIN;
          end else if (f != FW'(N - 1)) begin
            c_nxt     = '0;
            r_nxt     = '0;
            f_nxt     = f + FW'(1);
            state_nxt = LOAD_F;
          end else begin
            c_nxt     = '0;
            r_nxt     = '0;
            f_nxt     = '0;
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    mem_ren = rd_filter | rd_window;
  end

  // Read data lands one cycle after the address, so buffer and MAC strobes trail by one
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fbuf_we  <= 1'b0;
      fbuf_idx <= '0;
      mac_en   <= 1'b0;
      mac_k    <= '0;
    end else begin
      fbuf_we  <= rd_filter;
      fbuf_idx <= rd_filter ? k : '0;
      mac_en   <= rd_window;
      mac_k    <= rd_window ? k : '0;
    end
  end

  cnn_win_addr_gen #(
    .IMG (IMG),
    .K   (K),
    .AW  (AW),
    .OAW (OAW),
    .FW  (FW),
    .RW  (RW),
    .KW  (KW)
  ) u_addr (
    .clk       (clk),
    .rst       (rst),
    .capture   (capture),
    .x_inp     (x_inp),
    .y_inp     (y_inp),
    .z_inp     (z_inp),
    .f         (f),
    .r         (r),
    .c         (c),
    .k         (k),
    .rd_filter (rd_filter),
    .rd_window (rd_window),
    .wr_out    (out_valid),
    .mem_raddr (mem_raddr),
    .out_addr  (out_addr)
  );

endmodule

// File: tb/tb_cnn_seq_ctrl.sv
// Self-checking bench for cnn_seq_ctrl at default geometry: a nested-loop
// model queues every expected read, buffer index, MAC index and write.
module tb_cnn_seq_ctrl;

  localparam int N      = 4;
  localparam int IMG    = 16;
  localparam int K      = 4;
  localparam int KK     = K * K;
  localparam int OW     = IMG - K + 1;
  localparam int OUTS   = OW * OW;
  localparam int AW     = 9;
  localparam int OAW    = 10;
  localparam int KW     = 4;
  localparam int BUDGET = 13000;

  logic           clk;
  logic           rst;
  logic           start;
  logic [AW-1:0]  x_inp;
  logic [AW-1:0]  y_inp;
  logic [7:0]     z_inp;
  logic           mem_ren;
  logic [AW-1:0]  mem_raddr;
  logic           fbuf_we;
  logic [KW-1:0]  fbuf_idx;
  logic           mac_clr;
  logic           mac_en;
  logic [KW-1:0]  mac_k;
  logic           out_valid;
  logic [OAW-1:0] out_addr;
  logic           out_ready;
  logic           busy;
  logic           done;

  typedef struct {
    logic [AW-1:0] addr;
    logic          clr;
  } rd_exp_t;

  rd_exp_t        rd_q[$];
  logic [KW-1:0]  fidx_q[$];
  logic [KW-1:0]  mk_q[$];
  logic [OAW-1:0] wr_q[$];

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int done_cnt    = 0;
  int done_cyc    = 0;
  int wr_seen     = 0;
  int valid_cycles = 0;
  logic [OAW-1:0] first_out;
  logic [OAW-1:0] last_out;

  cnn_seq_ctrl #(
    .N   (N),
    .IMG (IMG),
    .K   (K),
    .AW  (AW),
    .OAW (OAW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .x_inp     (x_inp),
    .y_inp     (y_inp),
    .z_inp     (z_inp),
    .mem_ren   (mem_ren),
    .mem_raddr (mem_raddr),
    .fbuf_we   (fbuf_we),
    .fbuf_idx  (fbuf_idx),
    .mac_clr   (mac_clr),
    .mac_en    (mac_en),
    .mac_k     (mac_k),
    .out_valid (out_valid),
    .out_addr  (out_addr),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_mem_ren"},   32'(mem_ren),   32'd0);
    chk({tag, "_mem_raddr"}, 32'(mem_raddr), 32'd0);
    chk({tag, "_fbuf_we"},   32'(fbuf_we),   32'd0);
    chk({tag, "_fbuf_idx"},  32'(fbuf_idx),  32'd0);
    chk({tag, "_mac_clr"},   32'(mac_clr),   32'd0);
    chk({tag, "_mac_en"},    32'(mac_en),    32'd0);
    chk({tag, "_mac_k"},     32'(mac_k),     32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_addr"},  32'(out_addr),  32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
    chk({tag, "_done"},      32'(done),      32'd0);
  endtask

  task automatic push_run(input logic [AW-1:0] xv, input logic [AW-1:0] yv, input logic [7:0] zv);
    rd_exp_t e;
    rd_q.delete();
    fidx_q.delete();
    mk_q.delete();
    wr_q.delete();
    done_cnt     = 0;
    done_cyc     = 0;
    wr_seen      = 0;
    valid_cycles = 0;
    for (int f = 0; f < N; f++) begin
      for (int k = 0; k < KK; k++) begin
        e.addr = AW'(int'(yv) + f * KK + k);
        e.clr  = 1'b0;
        rd_q.push_back(e);
        fidx_q.push_back(KW'(k));
      end
      for (int r = 0; r < OW; r++) begin
        for (int c = 0; c < OW; c++) begin
          for (int k = 0; k < KK; k++) begin
            e.addr = AW'(int'(xv) + (r + k / K) * IMG + c + k % K);
            e.clr  = (k == 0);
            rd_q.push_back(e);
            mk_q.push_back(KW'(k));
          end
          wr_q.push_back(OAW'(int'(zv) + f * OUTS + r * OW + c));
        end
      end
    end
  endtask

  task automatic check_output();
    rd_exp_t e;
    if (mem_ren === 1'b1) begin
      chk("rd_pending", 32'(rd_q.size() > 0), 32'd1);
      if (rd_q.size() > 0) begin
        e = rd_q.pop_front();
        chk("mem_raddr", 32'(mem_raddr), 32'(e.addr));
        chk("mac_clr", 32'(mac_clr), 32'(e.clr));
      end
    end else begin
      chk("mac_clr_noread", 32'(mac_clr), 32'd0);
    end
    if (fbuf_we === 1'b1) begin
      chk("fbuf_pending", 32'(fidx_q.size() > 0), 32'd1);
      if (fidx_q.size() > 0) chk("fbuf_idx", 32'(fbuf_idx), 32'(fidx_q.pop_front()));
    end
    if (mac_en === 1'b1) begin
      chk("mac_pending", 32'(mk_q.size() > 0), 32'd1);
      if (mk_q.size() > 0) chk("mac_k", 32'(mac_k), 32'(mk_q.pop_front()));
    end
    if (out_valid === 1'b1) begin
      valid_cycles++;
      chk("wr_pending", 32'(wr_q.size() > 0), 32'd1);
      if (wr_q.size() > 0) chk("out_addr", 32'(out_addr), 32'(wr_q[0]));
      chk("no_read_in_write", 32'(mem_ren), 32'd0);
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  // One clock: note the handshake that the coming edge completes, then sample 1ns after it
  task automatic tick();
    logic           hs;
    logic [OAW-1:0] hs_addr;
    hs      = (out_valid === 1'b1) && (out_ready === 1'b1);
    hs_addr = out_addr;
    @(posedge clk);
    #1;
    cyc++;
    if (hs) begin
      if (wr_q.size() > 0) void'(wr_q.pop_front());
      if (wr_seen == 0) first_out = hs_addr;
      last_out = hs_addr;
      wr_seen++;
    end
    check_output();
  endtask

  task automatic apply_stimulus(input string tag, input logic [AW-1:0] xv, input logic [AW-1:0] yv,
                                input logic [7:0] zv, input bit pulse, input int ign_at,
                                input int stall_len, input int abort_at, input bit chain,
                                input int exp_done, input logic [OAW-1:0] exp_first,
                                input logic [OAW-1:0] exp_last);
    int stall_left;
    bit stalled;
    stall_left = 0;
    stalled    = 1'b0;
    $display("[TB] %s: x=%0d y=%0d z=%0d", tag, xv, yv, zv);
    x_inp = xv;
    y_inp = yv;
    z_inp = zv;
    if (pulse) begin
      push_run(xv, yv, zv);
      start = 1'b1;
      cyc   = 0;
      tick();
      start = 1'b0;
    end
    while (done_cnt == 0 && cyc < BUDGET && (abort_at == 0 || cyc < abort_at)) begin
      if (ign_at != 0 && cyc == ign_at) begin
        start = 1'b1;
        x_inp = ~xv;
        y_inp = ~yv;
        z_inp = ~zv;
      end else begin
        start = 1'b0;
      end
      tick();
      if (stall_len > 0 && !stalled && out_valid === 1'b1) begin
        stalled    = 1'b1;
        stall_left = stall_len;
        out_ready  = 1'b0;
      end else if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) out_ready = 1'b1;
      end
    end
    if (abort_at != 0) begin
      #2;
      rst = 1'b0;
      #1;
      check_zero("abort");
      repeat (20) tick();
      chk("abort_no_done", 32'(done_cnt), 32'd0);
      rst = 1'b1;
      rd_q.delete();
      fidx_q.delete();
      mk_q.delete();
      wr_q.delete();
    end else begin
      chk("done_cycle", 32'(done_cyc), 32'(exp_done));
      chk("first_out", 32'(first_out), 32'(exp_first));
      chk("last_out", 32'(last_out), 32'(exp_last));
      chk("valid_cycles", 32'(valid_cycles), 32'(N * OUTS + stall_len));
      chk("rd_left", 32'(rd_q.size()), 32'd0);
      chk("fbuf_left", 32'(fidx_q.size()), 32'd0);
      chk("mac_left", 32'(mk_q.size()), 32'd0);
      chk("wr_left", 32'(wr_q.size()), 32'd0);
      if (chain) begin
        start = 1'b1;
        tick();
        chk("chain_idle_busy", 32'(busy), 32'd0);
        chk("done_width", 32'(done), 32'd0);
        push_run(xv, yv, zv);
        cyc = 0;
        tick();
        start = 1'b0;
        chk("chain_busy", 32'(busy), 32'd1);
      end else begin
        tick();
        chk("done_width", 32'(done), 32'd0);
        chk("busy_after", 32'(busy), 32'd0);
      end
    end
  endtask

  initial begin
    rst       = 1'b0;
    start     = 1'b0;
    out_ready = 1'b1;
    x_inp     = 9'd64;
    y_inp     = 9'd0;
    z_inp     = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_ren", 32'(mem_ren), 32'd0);
    end

    apply_stimulus("defaults_ignored_start", 9'd64, 9'd0, 8'd0, 1'b1, 100, 0, 0, 1'b0,
                   12237, 10'd0, 10'd675);
    apply_stimulus("backpressure_chain", 9'd64, 9'd0, 8'd0, 1'b1, 0, 5, 0, 1'b1,
                   12242, 10'd0, 10'd675);
    apply_stimulus("abort", 9'd64, 9'd0, 8'd0, 1'b0, 0, 0, 500, 1'b0,
                   0, 10'd0, 10'd0);
    apply_stimulus("wrap", 9'd300, 9'd0, 8'd255, 1'b1, 0, 0, 0, 1'b0,
                   12237, 10'd255, 10'd930);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cnn_seq_ctrl.md
Name: cnn_seq_ctrl

Overview:
- Sequencer for the CNN convolution datapath. On `start` it captures the image base (`x_inp`), the filter base (`y_inp`) and the output base (`z_inp`), then works through N filters.
- For each filter it loads the KxK kernel from shared memory into the filter buffer. It then slides a KxK window (stride 1) across the IMGxIMG image, driving memory reads and the MAC enables, and issues one output write per window.
- It sits between the top-level start/done interface and the memory, filter-buffer, MAC and output-writer datapath blocks.

Parameters:
- N, 4, number of filters.
- IMG, 16, image side length in words.
- K, 4, kernel side length.
- AW, $clog2(N*K*K+IMG*IMG), memory address width (9 at defaults).
- OAW, $clog2(N*(IMG-K+1)**2+256), output address width (10 at defaults).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- x_inp  in  AW  image base address.
- y_inp  in  AW  filter base address.
- z_inp  in  8  output base address.
- mem_ren  out  1  memory read enable; read data valid the following cycle.
- mem_raddr  out  AW  memory read address.
- fbuf_we  out  1  filter buffer write enable.
- fbuf_idx  out  $clog2(K*K)  filter buffer write index.
- mac_clr  out  1  clear accumulator.
- mac_en  out  1  accumulate current mem data times kernel[mac_k].
- mac_k  out  $clog2(K*K)  kernel index for the MAC.
- out_valid  out  1  accumulator result ready to write.
- out_addr  out  OAW  output write address.
- out_ready  in  1  writer accepts the result.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (rst=0, asynchronous):
  - state goes to IDLE; all counters clear.
  - every output is 0.
- Input capture: x, y, z are registered on the edge where IDLE sees start=1. Inputs are ignored after that edge.
- Derived sizes: OW = IMG-K+1 (13 at defaults); OUTS = OW*OW (169).
- Counters:
  - f: filter, 0..N-1.
  - r, c: output row and column, 0..OW-1.
  - k: kernel index, 0..K*K-1, split as i = k/K, j = k%K.
- IDLE:
  - start=1 → LOAD_F with f=0, k=0.
  - start=0 → stay in IDLE.
- LOAD_F (K*K cycles):
  - mem_ren=1, mem_raddr = y + f*K*K + k.
  - After k = K*K-1 → LOAD_F_DRN.
- LOAD_F_DRN (1 cycle): no read; leads to WIN with r=c=0, k=0.
- Filter buffer timing: fbuf_we=1 with fbuf_idx = k delayed by one cycle. It is therefore active during LOAD_F cycles 1..K*K-1 and during LOAD_F_DRN.
- WIN (K*K cycles):
  - mem_ren=1, mem_raddr = x + (r+i)*IMG + (c+j).
  - mac_clr=1 in the first WIN cycle of each window.
  - After k = K*K-1 → WIN_DRN.
- MAC timing: mac_en=1 with mac_k = delayed k. It is active during WIN cycles 1..K*K-1 and during WIN_DRN.
- WIN_DRN (1 cycle) → WRITE.
- WRITE:
  - out_valid=1, out_addr = zero-extended z + f*OUTS + r*OW + c.
  - out_valid and out_addr hold stable until out_ready=1.
  - On that handshake edge, advance c, then r, then f.
- After WRITE:
  - Next window in the same filter → WIN.
  - Next filter → LOAD_F.
  - After the last write of filter N-1 → DONE.
- DONE (1 cycle): done=1, then IDLE. busy=0 in that IDLE.
- Address arithmetic is unsigned and wraps modulo 2^AW (memory) or 2^OAW (output).
- Latency with out_ready held at 1:
  - 18 cycles per window; 17 cycles per filter load.
  - done is high on cycle N*(17+OUTS*18)+1 after the start-capture edge (cycle 1 = first LOAD_F). At defaults this is cycle 12237.
- Boundary cases:
  - start while busy is ignored; back-to-back runs require passing through IDLE.
  - start held high across DONE causes a new run on the IDLE cycle.
  - out_ready may be held low indefinitely; all other outputs freeze during the stall.
  - rst asserted mid-run aborts immediately. No done pulse is produced; all outputs drop to 0.
  - z=255 with a large offset wraps in OAW bits; this is not an error.

Decomposition:
- Package cnn_pkg: state enum (IDLE, LOAD_F, LOAD_F_DRN, WIN, WIN_DRN, WRITE, DONE), localparams OW, OUTS, KK, and AW/OAW helper functions.
- Sub-module cnn_win_addr_gen: combinational plus registered computation of mem_raddr and out_addr from f/r/c/k and the captured bases. The FSM and counters stay in cnn_seq_ctrl.

Test Plan:
- Reset behaviour: with rst=0, then rst=1 and no start → all outputs 0; busy=0 for 100 cycles.
- Defaults run: x=64, y=0, z=0, start pulsed one cycle, out_ready=1.
  - First LOAD_F addresses are 0..15.
  - First WIN addresses are 64,65,66,67,80..83,96..99,112..115.
  - First out_addr is 0; the last out_addr is 675.
  - done is high on cycle 12237 for exactly 1 cycle.
- Window stepping: at r=1, c=12, f=2 → WIN addresses begin at 64+16+12=92; out_addr = 2*169+25 = 363. Filter 2 load addresses are 32..47.
- Back-pressure: out_ready=0 for 5 cycles at the first WRITE → out_valid and out_addr=0 held for 6 cycles; no mem_ren; total latency grows by 5.
- Ignored start and abort: start pulsed at cycle 100 mid-run → no effect on addresses. rst=0 at cycle 500 → outputs 0 asynchronously and done never pulses. A new start after release begins again at address y.
- Wrap: x=300, y=0, z=255 → the first window's last address is (300+3*16+3) mod 512 = 351. Last out_addr = (255+675) mod 1024 = 930.
